timer_ctrl: RTL and testbench

Programmable interval-timer controller that sequences a 4-bit synchronous up-counter (the toggle-chain counter used in the lab designs) as a shared time base. It starts, pauses, aborts and restarts the counter, detects terminal count against a latched limit, and raises a one-cycle `done` pulse and a sticky `irq`. It sits between a host/control FSM and the counter datapath. The counter is never free-running; it only advances under this block's control.

---
 rtl/timer_ctrl_pkg.sv | 16 +
 rtl/timer_count_core.sv | 35 +++
 rtl/timer_ctrl.sv | 99 +++++++++
 tb/tb_timer_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encoding and defaults for the interval timer
package timer_ctrl_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/timer_count_core.sv
// rtl/timer_count_core.sv - synchronous up-counter built from toggle stages
module timer_count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] toggle;
    logic             carry;

    // A stage toggles only when every lower stage is 1 and inc is asserted.
    always_comb begin
        toggle = '0;
        carry  = inc;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = carry;
            carry     = carry & q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= q ^ toggle;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - interval-timer controller sequencing the shared toggle counter
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] lim_r;
    logic             per_r;
    logic             clr, inc, tc, latch;

    timer_count_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc),
        .q   (count)
    );

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        inc      = 1'b0;
        tc       = 1'b0;
        latch    = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            clr      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clr = 1'b1;
                    if (start) begin
                        latch    = 1'b1;
                        state_nx = RUN;
                    end
                end
                RUN, PAUSE: begin
                    // Leaving PAUSE counts as a run cycle so each paused cycle costs exactly one.
                    if ((state == PAUSE) && pause) begin
                        state_nx = PAUSE;
                    end else if (count == lim_r) begin
                        tc       = 1'b1;
                        clr      = 1'b1;
                        state_nx = per_r ? (pause ? PAUSE : RUN) : IDLE;
                    end else if (pause) begin
                        state_nx = PAUSE;
                    end else begin
                        inc      = 1'b1;
                        state_nx = RUN;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    clr      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lim_r <= '0;
            per_r <= 1'b0;
            done  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= tc;
            if (latch) begin
                lim_r <= limit;
                per_r <= periodic;
            end
            if (tc) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

    assign busy = is_busy(state);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl
module tb_timer_ctrl;

    typedef struct packed {
        logic [3:0] count;
        logic       busy;
        logic       done;
        logic       irq;
    } out_t;

    logic       clk, rst, start, pause, abort, periodic, irq_ack;
    logic [3:0] limit, count;
    logic       busy, done, irq;

    out_t exp_q[$];
    out_t obs_q[$];
    out_t e, o;
    int   vectors = 0;
    int   miscompares = 0;

    timer_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .periodic (periodic),
        .limit    (limit),
        .irq_ack  (irq_ack),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: expectation queued with the stimulus, observation captured 1ns after the edge.
    task automatic step(input int ec, input bit eb, input bit ed, input bit ei);
        exp_q.push_back('{count: 4'(ec), busy: eb, done: ed, irq: ei});
        @(posedge clk);
        #1;
        obs_q.push_back('{count: count, busy: busy, done: done, irq: irq});
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; pause = 0; abort = 0; periodic = 0; irq_ack = 0; limit = 0;
        @(posedge clk);
        #1;
        vectors++;
        if ({count, busy, done, irq} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset: got count=%0d busy=%b done=%b irq=%b want all 0", count, busy, done, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL reset_idle[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_oneshot;
        start = 1; limit = 5; periodic = 0;
        step(0, 1, 0, 0);
        start = 0; limit = 2;
        for (int n = 1; n <= 5; n++) step(n, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        irq_ack = 1;
        step(0, 0, 0, 0);
        irq_ack = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL oneshot[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_periodic;
        start = 1; limit = 3; periodic = 1;
        step(0, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 12; i++) begin
            // A start while busy must not re-latch a shorter one-shot limit.
            start = (i == 2); limit = (i == 2) ? 4'd1 : 4'd3; periodic = (i != 2);
            step(i % 4, 1, (i % 4) == 0, i >= 4);
        end
        start = 0; abort = 1;
        step(0, 0, 0, 1);
        abort = 0; irq_ack = 1;
        step(0, 0, 0, 0);
        irq_ack = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL periodic[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_pause;
        start = 1; limit = 7; periodic = 0;
        step(0, 1, 0, 0);
        start = 0;
        for (int n = 1; n <= 4; n++) step(n, 1, 0, 0);
        pause = 1;
        for (int n = 0; n < 3; n++) step(4, 1, 0, 0);
        pause = 0;
        for (int n = 5; n <= 7; n++) step(n, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL pause[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_abort;
        // irq is still set from the paused run and must survive the abort.
        start = 1; limit = 9; periodic = 0;
        step(0, 1, 0, 1);
        start = 0;
        step(1, 1, 0, 1);
        step(2, 1, 0, 1);
        abort = 1;
        step(0, 0, 0, 1);
        abort = 0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        irq_ack = 1;
        step(0, 0, 0, 0);
        irq_ack = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL abort[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_limit_zero;
        start = 1; limit = 0; periodic = 1;
        step(0, 1, 0, 0);
        start = 0;
        for (int n = 0; n < 4; n++) begin
            irq_ack = (n == 2);
            step(0, 1, 1, 1);
        end
        irq_ack = 0; abort = 1;
        step(0, 0, 0, 1);
        abort = 0; irq_ack = 1;
        step(0, 0, 0, 0);
        irq_ack = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL limit0[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_wrap;
        start = 1; limit = 15; periodic = 0;
        step(0, 1, 0, 0);
        start = 0;
        for (int n = 1; n <= 15; n++) step(n, 1, 0, 0);
        irq_ack = 1;
        step(0, 0, 1, 1);
        irq_ack = 0;
        step(0, 0, 0, 1);
        irq_ack = 1;
        step(0, 0, 0, 0);
        irq_ack = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL wrap[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_tc_with_pause;
        start = 1; limit = 2; periodic = 1;
        step(0, 1, 0, 0);
        start = 0;
        step(1, 1, 0, 0);
        step(2, 1, 0, 0);
        pause = 1;
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        pause = 0;
        step(1, 1, 0, 1);
        step(2, 1, 0, 1);
        step(0, 1, 1, 1);
        abort = 1; irq_ack = 1;
        step(0, 0, 0, 0);
        abort = 0; irq_ack = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL tc_pause[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_async_reset;
        start = 1; limit = 0; periodic = 1;
        step(0, 1, 0, 0);
        start = 0;
        step(0, 1, 1, 1);
        #2;
        rst = 1;
        #1;
        vectors++;
        if ({count, busy, done, irq} !== 7'b0) begin
            miscompares++;
            $display("FAIL async_rst: got count=%0d busy=%b done=%b irq=%b want all 0", count, busy, done, irq);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        start = 1; limit = 2; periodic = 0;
        step(0, 1, 0, 0);
        start = 0;
        step(1, 1, 0, 0);
        step(2, 1, 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL async_restart[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_abort();
        test_limit_zero();
        test_wrap();
        test_tc_with_pause();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
